reconf_dsp_seq: RTL

RECONF_DSP_SEQ -- requirements
Module: reconf_dsp_seq

---
 rtl/reconf_dsp_seq.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/reconf_dsp_seq.sv
// Microcoded sequencer that replays a small program of DSP control words,
// looping between loop_start and END words. Optional stall counter: RECONF_DSP_SEQ_STATS_EN.
module reconf_dsp_seq #(
  parameter int FIFO_PA_BITS = 5,
  parameter int FIFO_PD_BITS = 5,
  parameter int FIFO_PF_BITS = 5,
  parameter int CMD_WIDTH    = 3,
  parameter int PROG_BITS    = 6,
  parameter int IW           = FIFO_PA_BITS + FIFO_PD_BITS + FIFO_PF_BITS + CMD_WIDTH + 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [PROG_BITS-1:0]    cfg_addr,
  input  logic [IW-1:0]           cfg_data,
  input  logic [PROG_BITS-1:0]    loop_start,
  input  logic [15:0]             iter_count,
  input  logic                    start,
  input  logic                    stop,
  output logic                    busy,
  output logic                    done,
  output logic [FIFO_PA_BITS-1:0] exe_faa,
  output logic [FIFO_PD_BITS-1:0] exe_fad,
  output logic [FIFO_PF_BITS-1:0] exe_fac,
  output logic                    exe_pa_l,
  output logic                    exe_pd_l,
  output logic                    exe_pc_l,
  output logic                    exe_pi_r,
  output logic                    exe_pp_l,
  output logic [CMD_WIDTH-1:0]    exe_cmd,
  output logic                    exe_cfg_omux,
  input  logic                    exe_ready,
  output logic [31:0]             stat_stall
);

  // Handshake: a command is taken on a clk edge where busy=1 and exe_ready=1;
  // the presented word never depends on exe_ready, only on the registered pc.
  localparam int DEPTH    = 1 << PROG_BITS;
  localparam int OFF_FAD  = FIFO_PA_BITS;
  localparam int OFF_FAC  = OFF_FAD + FIFO_PD_BITS;
  localparam int OFF_PA_L = OFF_FAC + FIFO_PF_BITS;
  localparam int OFF_PD_L = OFF_PA_L + 1;
  localparam int OFF_PC_L = OFF_PD_L + 1;
  localparam int OFF_PI_R = OFF_PC_L + 1;
  localparam int OFF_PP_L = OFF_PI_R + 1;
  localparam int OFF_CMD  = OFF_PP_L + 1;
  localparam int OFF_OMUX = OFF_CMD + CMD_WIDTH;
  localparam int OFF_END  = OFF_OMUX + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IW-1:0]        r_mem [DEPTH];
  logic [PROG_BITS-1:0] r_pc;
  logic [PROG_BITS-1:0] r_loop;
  logic [15:0]          r_pass;
  logic [15:0]          r_iter;
  logic [15:0]          w_pass_inc;
  logic [IW-1:0]        w_word;
  logic                 w_run;
  logic                 w_go;
  logic                 w_accept;
  logic                 w_end;
  logic                 w_last;

  assign w_run      = (r_state == S_RUN);
  assign w_go       = (r_state == S_IDLE) && start && !stop;
  assign w_word     = r_mem[r_pc];
  assign w_end      = w_word[OFF_END];
  assign w_accept   = w_run && exe_ready && !stop;
  assign w_pass_inc = r_pass + 16'd1;
  assign w_last     = (r_iter != 16'd0) && (w_pass_inc == r_iter);

  // Program memory is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (cfg_we && (r_state == S_IDLE)) r_mem[cfg_addr] <= cfg_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_go) w_state_nxt = S_RUN;
      S_RUN: begin
        if (stop)                           w_state_nxt = S_IDLE;
        else if (w_accept && w_end && w_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = w_run;
    done         = (r_state == S_DONE);
    exe_faa      = '0;
    exe_fad      = '0;
    exe_fac      = '0;
    exe_pa_l     = 1'b0;
    exe_pd_l     = 1'b0;
    exe_pc_l     = 1'b0;
    exe_pi_r     = 1'b0;
    exe_pp_l     = 1'b0;
    exe_cmd      = '0;
    exe_cfg_omux = 1'b0;
    if (w_run) begin
      exe_faa      = w_word[0 +: FIFO_PA_BITS];
      exe_fad      = w_word[OFF_FAD +: FIFO_PD_BITS];
      exe_fac      = w_word[OFF_FAC +: FIFO_PF_BITS];
      exe_pa_l     = w_word[OFF_PA_L];
      exe_pd_l     = w_word[OFF_PD_L];
      exe_pc_l     = w_word[OFF_PC_L];
      exe_pi_r     = w_word[OFF_PI_R];
      exe_pp_l     = w_word[OFF_PP_L];
      exe_cmd      = w_word[OFF_CMD +: CMD_WIDTH];
      exe_cfg_omux = w_word[OFF_OMUX];
    end
  end

  // Run parameters are latched at launch so the host may change them mid-run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= '0;
      r_pass <= '0;
      r_iter <= '0;
      r_loop <= '0;
    end else if (w_go) begin
      r_pc   <= '0;
      r_pass <= '0;
      r_iter <= iter_count;
      r_loop <= loop_start;
    end else if (w_accept) begin
      if (w_end) begin
        r_pass <= w_pass_inc;
        if (!w_last) r_pc <= r_loop;
      end else begin
        r_pc <= r_pc + 1'b1;
      end
    end
  end

`ifdef RECONF_DSP_SEQ_STATS_EN
  logic [31:0] r_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       r_stall <= '0;
    else if (w_go)                                    r_stall <= '0;
    else if (w_run && !exe_ready && (r_stall != '1))  r_stall <= r_stall + 32'd1;
  end

  assign stat_stall = r_stall;
`else
  assign stat_stall = '0;
`endif

endmodule
